// File: rtl/sw_mux_pkg.sv
// Shared types and constants for the switch/button front end of the 4:1 selector.
package sw_mux_pkg;

    localparam int unsigned SEL_W_DEF = 2;
    localparam int unsigned SCAN_MAX  = (1 << SEL_W_DEF) - 1;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        SCAN   = 2'd1,
        HOLD   = 2'd2
    } state_e;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a per-bit stability counter.
// level is the accepted value; level_d is the value it takes on the next edge.
module sw_debounce #(
    parameter int unsigned W          = 1,
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] raw,
    output logic [W-1:0] level,
    output logic [W-1:0] level_d
);

    localparam int unsigned      CNT_W    = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [W-1:0]     sync1_q, sync2_q, stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [W];
    logic [CNT_W-1:0] cnt_d [W];

    always_comb begin
        stable_d = stable_q;
        for (int unsigned i = 0; i < W; i++) begin
            cnt_d[i] = '0;
            // Any return to the accepted level restarts the count.
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '{default: '0};
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level   = stable_q;
    assign level_d = stable_d;

endmodule

// File: rtl/sw_mux_driver.sv
// Board input stage for the 4:1 x 2-bit selector: debounced data/select switches,
// plus a manual/scan/hold mode machine that can step the select automatically.
module sw_mux_driver
    import sw_mux_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned SEL_W      = SEL_W_DEF,
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned SCAN_DIV   = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw_a,
    input  logic [SEL_W-1:0]  sw_s,
    input  logic              btn_mode,
    input  logic              btn_step,
    output logic [DATA_W-1:0] a,
    output logic [SEL_W-1:0]  s,
    output logic              scan_active,
    output logic              sel_changed
);

    localparam int unsigned      DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DATA_W-1:0] a_lvl_d_unused;
    logic [SEL_W-1:0]  s_lvl_unused, s_lvl_d;
    logic [1:0]        btn_lvl, btn_lvl_d, btn_press;
    logic              mode_press, step_press;

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  s_q, s_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              scan_active_q, scan_active_d;
    logic              sel_changed_q, sel_changed_d;

    sw_debounce #(.W(DATA_W), .DEB_CYCLES(DEB_CYCLES)) u_deb_a (
        .clk(clk), .rst_n(rst_n), .raw(sw_a), .level(a), .level_d(a_lvl_d_unused)
    );

    sw_debounce #(.W(SEL_W), .DEB_CYCLES(DEB_CYCLES)) u_deb_s (
        .clk(clk), .rst_n(rst_n), .raw(sw_s), .level(s_lvl_unused), .level_d(s_lvl_d)
    );

    sw_debounce #(.W(2), .DEB_CYCLES(DEB_CYCLES)) u_deb_btn (
        .clk(clk), .rst_n(rst_n), .raw({btn_mode, btn_step}), .level(btn_lvl), .level_d(btn_lvl_d)
    );

    // Press is taken in the cycle the debounced level is about to rise, so the
    // manual select path and the mode machine both act on the same edge.
    assign btn_press  = btn_lvl_d & ~btn_lvl;
    assign mode_press = btn_press[1];
    assign step_press = btn_press[0];

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        div_d   = '0;
        unique case (state_q)
            MANUAL: begin
                s_d = s_lvl_d;
                if (mode_press) begin
                    state_d = SCAN;
                    s_d     = s_q;
                end
            end
            SCAN: begin
                if (mode_press) begin
                    state_d = MANUAL;
                end else if (step_press) begin
                    state_d = HOLD;
                end else if (div_q == DIV_LAST) begin
                    s_d = s_q + SEL_W'(1);
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            HOLD: begin
                if (mode_press) begin
                    state_d = MANUAL;
                end else if (step_press) begin
                    s_d = s_q + SEL_W'(1);
                end
            end
            default: state_d = MANUAL;
        endcase
        scan_active_d = (state_d != MANUAL);
        sel_changed_d = (s_d != s_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= MANUAL;
            s_q           <= '0;
            div_q         <= '0;
            scan_active_q <= 1'b0;
            sel_changed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            s_q           <= s_d;
            div_q         <= div_d;
            scan_active_q <= scan_active_d;
            sel_changed_q <= sel_changed_d;
        end
    end

    assign s           = s_q;
    assign scan_active = scan_active_q;
    assign sel_changed = sel_changed_q;

endmodule

// File: tb/tb_sw_mux_driver.sv
// Directed bench for sw_mux_driver with DEB_CYCLES=4, SCAN_DIV=8.
module tb_sw_mux_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw_a;
    logic [1:0] sw_s;
    logic       btn_mode, btn_step;
    logic [7:0] a;
    logic [1:0] s;
    logic       scan_active, sel_changed;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    sw_mux_driver #(
        .DATA_W(8), .SEL_W(2), .DEB_CYCLES(4), .SCAN_DIV(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw_a(sw_a), .sw_s(sw_s),
        .btn_mode(btn_mode), .btn_step(btn_step),
        .a(a), .s(s), .scan_active(scan_active), .sel_changed(sel_changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cyc(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; sw_a = '0; sw_s = '0; btn_mode = 1'b0; btn_step = 1'b0;
        cyc(3);
        check("rst_a", a, 0);
        check("rst_s", s, 0);
        check("rst_scan", scan_active, 0);
        check("rst_sel", sel_changed, 0);
        rst_n = 1'b1;
        cyc(2);
        check("rel_sel", sel_changed, 0);

        // Debounce latency and glitch rejection
        sw_a = 8'hA5;
        cyc(5);  check("deb_a_early", a, 8'h00);
        cyc(1);  check("deb_a_edge6", a, 8'hA5);
        sw_a = 8'hA4;
        cyc(3);
        sw_a = 8'hA5;
        cyc(10); check("glitch_a", a, 8'hA5);

        // Manual select
        sw_s = 2'd2;
        cyc(5);  check("man_s_early", s, 2'd0);
                 check("man_sel_early", sel_changed, 0);
        cyc(1);  check("man_s", s, 2'd2);
                 check("man_sel_pulse", sel_changed, 1);
        cyc(1);  check("man_sel_drop", sel_changed, 0);

        // Scan from 3
        sw_s = 2'd3;
        cyc(10); check("man_s3", s, 2'd3);
        btn_mode = 1'b1;
        cyc(5);  check("scan_pre", scan_active, 0);
        cyc(1);  check("scan_on", scan_active, 1);
                 check("scan_s3", s, 2'd3);
        btn_mode = 1'b0;
        cyc(7);  check("scan_s3_hold", s, 2'd3);
        cyc(1);  check("scan_s0", s, 2'd0);
                 check("scan_sel0", sel_changed, 1);
        cyc(1);  check("scan_sel0_drop", sel_changed, 0);
        cyc(6);  check("scan_s0_hold", s, 2'd0);
        cyc(1);  check("scan_s1", s, 2'd1);
                 check("scan_sel1", sel_changed, 1);
        cyc(8);  check("scan_s2", s, 2'd2);
                 check("scan_sel2", sel_changed, 1);

        // Hold and single-step
        btn_step = 1'b1;
        cyc(6);  check("hold_active", scan_active, 1);
                 check("hold_s", s, 2'd2);
        btn_step = 1'b0;
        cyc(40); check("hold_frozen", s, 2'd2);
        btn_step = 1'b1;
        cyc(5);  check("step_early", s, 2'd2);
        cyc(1);  check("step_s3", s, 2'd3);
                 check("step_sel", sel_changed, 1);
        btn_step = 1'b0;
        cyc(10); check("step_s3_stay", s, 2'd3);
        btn_step = 1'b1;
        cyc(6);  check("step_wrap", s, 2'd0);
                 check("step_wrap_sel", sel_changed, 1);
        btn_step = 1'b0;
        cyc(10);

        // Hold -> manual
        btn_mode = 1'b1;
        cyc(5);  check("h2m_pre", scan_active, 1);
        cyc(1);  check("h2m_scan", scan_active, 0);
                 check("h2m_s_held", s, 2'd0);
        cyc(1);  check("h2m_s", s, 2'd3);
                 check("h2m_sel", sel_changed, 1);
        btn_mode = 1'b0;
        cyc(10);

        // Simultaneous mode+step while scanning
        btn_mode = 1'b1;
        cyc(6);  check("rescan_on", scan_active, 1);
                 check("rescan_s", s, 2'd3);
        btn_mode = 1'b0;
        sw_s = 2'd1;
        cyc(7);  check("rescan_s3", s, 2'd3);
        btn_mode = 1'b1; btn_step = 1'b1;
        cyc(5);  check("both_pre_scan", scan_active, 1);
                 check("both_pre_s", s, 2'd0);
        cyc(1);  check("both_scan_off", scan_active, 0);
                 check("both_s_noinc", s, 2'd0);
        cyc(1);  check("both_s_man", s, 2'd1);
                 check("both_sel", sel_changed, 1);
        cyc(20); check("both_s_stay", s, 2'd1);
                 check("both_scan_stay", scan_active, 0);
        btn_mode = 1'b0; btn_step = 1'b0;
        cyc(10);

        // Async reset mid-scan
        btn_mode = 1'b1;
        cyc(6);  check("pre_rst_scan", scan_active, 1);
                 check("pre_rst_s1", s, 2'd1);
        btn_mode = 1'b0;
        cyc(10); check("pre_rst_s2", s, 2'd2);
        rst_n = 1'b0;
        #2;
        check("arst_a", a, 0);
        check("arst_s", s, 0);
        check("arst_scan", scan_active, 0);
        check("arst_sel", sel_changed, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);  check("rel2_sel1", sel_changed, 0);
                 check("rel2_s", s, 2'd0);
        cyc(1);  check("rel2_sel2", sel_changed, 0);
        cyc(3);  check("rel2_a_early", a, 8'h00);
        cyc(1);  check("rel2_a", a, 8'hA5);
                 check("rel2_s1", s, 2'd1);
                 check("rel2_sel", sel_changed, 1);
                 check("rel2_scan", scan_active, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
